// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the multicycle control unit.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b110;
   localparam logic [2:0] ALU_OR    = 3'b001;
   localparam logic [2:0] ALU_PASSB = 3'b000;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXE_R  = 4'd2,
      EXE_I  = 4'd3,
      ADDR   = 4'd4,
      MEM_RD = 4'd5,
      MEM_WR = 4'd6,
      WB_R   = 4'd7,
      WB_I   = 4'd8,
      WB_M   = 4'd9,
      BR     = 4'd10
   } state_t;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_mem_state(state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operand/operation decode: maps the current state and IR fields to
// alu_ctr, operand selects and immediate extension mode.
module mc_alu_dec
   import mc_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_ctr,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_ext_op
);

   state_t w_state;
   assign w_state = state_t'(i_state);

   always_comb begin
      o_alu_ctr   = ALU_PASSB;
      o_alu_src_a = 1'b0;
      o_alu_src_b = 2'b00;
      o_ext_op    = 2'b00;
      case (w_state)
         FETCH: begin
            o_alu_src_b = 2'b01;
            o_alu_ctr   = ALU_ADD;
         end
         DECODE: begin
            // Branch target precomputed speculatively into ALUOut.
            o_alu_src_b = 2'b11;
            o_ext_op    = 2'b01;
            o_alu_ctr   = ALU_ADD;
         end
         EXE_R: begin
            o_alu_src_a = 1'b1;
            o_alu_ctr   = (i_funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
         end
         EXE_I: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            if (i_op == OP_LUI) begin
               o_ext_op  = 2'b10;
               o_alu_ctr = ALU_PASSB;
            end else begin
               o_ext_op  = 2'b00;
               o_alu_ctr = ALU_OR;
            end
         end
         ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            o_ext_op    = 2'b01;
            o_alu_ctr   = ALU_ADD;
         end
         BR: begin
            o_alu_src_a = 1'b1;
            o_alu_ctr   = ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM with memory handshake and optional timeout.
// Define MC_CTRL_PERF_EN to add retired/cycles performance counters.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        pc_wr,
   output logic [1:0]  pc_src,
   output logic        ir_wr,
   output logic        mdr_wr,
   output logic        reg_wr,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  ext_op,
   output logic [2:0]  alu_ctr,
   output logic        illegal,
   output logic        err,
   output logic [3:0]  dbg_state
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] retired,
   output logic [31:0] cycles
`endif
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cnt;
   logic        r_err;
   logic        w_wait;
   logic        w_timeout;
   logic [2:0]  w_alu_ctr;
   logic        w_alu_src_a;
   logic [1:0]  w_alu_src_b;
   logic [1:0]  w_ext_op;

   mc_alu_dec u_alu_dec (
      .i_state     (r_state),
      .i_op        (op),
      .i_funct     (funct),
      .o_alu_ctr   (w_alu_ctr),
      .o_alu_src_a (w_alu_src_a),
      .o_alu_src_b (w_alu_src_b),
      .o_ext_op    (w_ext_op)
   );

   assign w_wait = is_mem_state(r_state) && !mem_ready;

   generate
      if (MEM_TIMEOUT > 0) begin : g_tmo
         assign w_timeout = w_wait && (r_cnt == 32'(MEM_TIMEOUT - 1));
      end else begin : g_no_tmo
         assign w_timeout = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_wait && !w_timeout) ? r_cnt + 32'd1 : '0;
         if (w_timeout) r_err <= 1'b1;
      end
   end

   // Everything is held at zero while rst_n is low, including the selects.
   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = 2'b00;
      ir_wr      = 1'b0;
      mdr_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      alu_ctr    = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_op     = 2'b00;
      if (rst_n) begin
         alu_ctr   = w_alu_ctr;
         alu_src_a = w_alu_src_a;
         alu_src_b = w_alu_src_b;
         ext_op    = w_ext_op;
         case (r_state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_wr  = 1'b1;
                  pc_wr  = 1'b1;
                  w_next = DECODE;
               end
            end
            DECODE: begin
               case (op)
                  OP_J: begin
                     pc_wr  = 1'b1;
                     pc_src = 2'b10;
                     w_next = FETCH;
                  end
                  OP_BEQ:        w_next = BR;
                  OP_LW, OP_SW:  w_next = ADDR;
                  OP_ORI, OP_LUI: w_next = EXE_I;
                  OP_RTYPE: begin
                     if (funct == FN_ADDU || funct == FN_SUBU) begin
                        w_next = EXE_R;
                     end else begin
                        illegal = 1'b1;
                        w_next  = FETCH;
                     end
                  end
                  default: begin
                     illegal = 1'b1;
                     w_next  = FETCH;
                  end
               endcase
            end
            EXE_R: w_next = WB_R;
            EXE_I: w_next = WB_I;
            ADDR:  w_next = (op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  mdr_wr = 1'b1;
                  w_next = WB_M;
               end
            end
            MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               if (mem_ready) w_next = FETCH;
            end
            WB_R: begin
               reg_wr  = 1'b1;
               reg_dst = 1'b1;
               w_next  = FETCH;
            end
            WB_I: begin
               reg_wr = 1'b1;
               w_next = FETCH;
            end
            WB_M: begin
               reg_wr     = 1'b1;
               mem_to_reg = 1'b1;
               w_next     = FETCH;
            end
            BR: begin
               pc_wr  = zero;
               pc_src = 2'b01;
               w_next = FETCH;
            end
            default: w_next = FETCH;
         endcase
         if (w_timeout) w_next = FETCH;
      end
   end

   assign err       = r_err;
   assign dbg_state = r_state;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] r_retired;
   logic [31:0] r_cycles;
   logic        w_retire;

   // Illegal and timeout exits return to FETCH without completing an instruction.
   assign w_retire = (r_state != FETCH) && (w_next == FETCH) && !illegal && !w_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
         r_cycles  <= '0;
      end else begin
         r_cycles <= r_cycles + 32'd1;
         if (w_retire) r_retired <= r_retired + 32'd1;
      end
   end

   assign retired = r_retired;
   assign cycles  = r_cycles;
`endif

endmodule
